// File: rtl/crc_stream_pkg.sv
// crc_pkg: shared types, limits and bit-reversal helpers for the streaming CRC engine
package crc_pkg;

   localparam int MAX_CRC_WIDTH  = 32;
   localparam int MAX_DATA_BYTES = 8;

   typedef enum logic {RUN, HOLD} state_t;

   function automatic logic [7:0] reflect8(input logic [7:0] b);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   function automatic logic [31:0] reflect_n(input logic [31:0] v, input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++)
         if (i < n) r[i] = v[n-1-i];
      return r;
   endfunction

endpackage

// File: rtl/crc_byte_step.sv
// crc_byte_step: combinational one-byte CRC update, pass-through when disabled
module crc_byte_step
   import crc_pkg::*;
#(
   parameter int                   CRC_WIDTH  = 8,
   parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = 8'h07,
   parameter bit                   REFLECT_IN = 1'b0
) (
   input  logic [CRC_WIDTH-1:0] crc_i,
   input  logic [7:0]           byte_i,
   input  logic                 en_i,
   output logic [CRC_WIDTH-1:0] crc_o
);

   logic [7:0]           b;
   logic [CRC_WIDTH-1:0] r;
   logic                 fb;

   // shift the byte in MSB-first, folding the polynomial in on each feedback bit
   always_comb begin
      b  = REFLECT_IN ? reflect8(byte_i) : byte_i;
      r  = crc_i;
      fb = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         fb = r[CRC_WIDTH-1] ^ b[i];
         r  = r << 1;
         r  = fb ? r ^ POLYNOMIAL : r;
      end
      crc_o = en_i ? r : crc_i;
   end

endmodule

// File: rtl/crc_stream.sv
// crc_stream: parametrised multi-byte streaming CRC with framed result handshake
module crc_stream
   import crc_pkg::*;
#(
   parameter int                   CRC_WIDTH   = 8,
   parameter logic [CRC_WIDTH-1:0] POLYNOMIAL  = 8'h07,
   parameter logic [CRC_WIDTH-1:0] INIT        = '0,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT     = '0,
   parameter bit                   REFLECT_IN  = 1'b0,
   parameter bit                   REFLECT_OUT = 1'b0,
   parameter logic [CRC_WIDTH-1:0] RESIDUE     = '0,
   parameter int                   DATA_BYTES  = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [8*DATA_BYTES-1:0] data_i,
   input  logic [DATA_BYTES-1:0]   keep_i,
   input  logic                    valid_i,
   input  logic                    last_i,
   output logic                    ready_o,
   output logic [CRC_WIDTH-1:0]    crc_o,
   output logic                    crc_valid_o,
   input  logic                    crc_ready_i,
   output logic                    match_o
);

   if (CRC_WIDTH < 1 || CRC_WIDTH > MAX_CRC_WIDTH || DATA_BYTES < 1 || DATA_BYTES > MAX_DATA_BYTES) begin : g_bad_params
      $error("crc_stream: CRC_WIDTH must be 1..32 and DATA_BYTES 1..8");
   end

   state_t               state, state_nx;
   logic [CRC_WIDTH-1:0] crc_q;
   logic [CRC_WIDTH-1:0] chain [DATA_BYTES+1];
   logic [CRC_WIDTH-1:0] final_crc;
   logic                 accept, frame_end;

   assign ready_o   = (state == RUN) && !rst_i;
   assign accept    = valid_i && ready_o;
   assign frame_end = accept && last_i;
   assign chain[0]  = crc_q;

   for (genvar k = 0; k < DATA_BYTES; k++) begin : g_step
      crc_byte_step #(
         .CRC_WIDTH  (CRC_WIDTH),
         .POLYNOMIAL (POLYNOMIAL),
         .REFLECT_IN (REFLECT_IN)
      ) u_step (
         .crc_i  (chain[k]),
         .byte_i (data_i[8*k +: 8]),
         .en_i   (keep_i[k]),
         .crc_o  (chain[k+1])
      );
   end

   // output transform applied to the register after the final beat's bytes
   always_comb begin
      final_crc = (REFLECT_OUT ? CRC_WIDTH'(reflect_n(32'(chain[DATA_BYTES]), CRC_WIDTH))
                               : chain[DATA_BYTES]) ^ XOR_OUT;
   end

   // RUN accepts beats until last; HOLD presents the result until the consumer takes it
   always_comb begin
      state_nx = state;
      state_nx = (state == RUN) ? (frame_end ? HOLD : RUN) : (crc_ready_i ? RUN : HOLD);
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= RUN;
      else       state <= state_nx;
   end

   // running CRC register and registered result outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_q       <= INIT;
         crc_o       <= '0;
         match_o     <= 1'b0;
         crc_valid_o <= 1'b0;
      end else begin
         crc_valid_o <= state_nx == HOLD;
         if (accept) crc_q <= last_i ? INIT : chain[DATA_BYTES];
         if (frame_end) begin
            crc_o   <= final_crc;
            match_o <= final_crc == RESIDUE;
         end
      end
   end

endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: randomized and directed checks of four crc_stream configurations against a frame-level model
module tb_crc_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cr;
   logic [7:0]  d1;
   logic        k1, v1, l1;
   logic [31:0] data;
   logic [3:0]  keep;
   logic        valid, last;
   logic        r0, r1, r2, r3, cv0, cv1, cv2, cv3, m0, m1, m2, m3;
   logic [7:0]  c0, c1;
   logic [15:0] c2;
   logic [31:0] c3;
   int          checks = 0, errors = 0;

   crc_stream u0 (
      .clk_i(clk), .rst_i(rst), .data_i(d1), .keep_i(k1), .valid_i(v1), .last_i(l1),
      .ready_o(r0), .crc_o(c0), .crc_valid_o(cv0), .crc_ready_i(cr), .match_o(m0));

   crc_stream #(.DATA_BYTES(4)) u1 (
      .clk_i(clk), .rst_i(rst), .data_i(data), .keep_i(keep), .valid_i(valid), .last_i(last),
      .ready_o(r1), .crc_o(c1), .crc_valid_o(cv1), .crc_ready_i(cr), .match_o(m1));

   crc_stream #(.CRC_WIDTH(16), .POLYNOMIAL(16'h1021), .INIT(16'hFFFF), .DATA_BYTES(4)) u2 (
      .clk_i(clk), .rst_i(rst), .data_i(data), .keep_i(keep), .valid_i(valid), .last_i(last),
      .ready_o(r2), .crc_o(c2), .crc_valid_o(cv2), .crc_ready_i(cr), .match_o(m2));

   crc_stream #(.CRC_WIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1),
                .RESIDUE(32'h2144DF1C), .DATA_BYTES(4)) u3 (
      .clk_i(clk), .rst_i(rst), .data_i(data), .keep_i(keep), .valid_i(valid), .last_i(last),
      .ready_o(r3), .crc_o(c3), .crc_valid_o(cv3), .crc_ready_i(cr), .match_o(m3));

   function automatic int wid(int l);
      return l == 3 ? 32 : l == 2 ? 16 : 8;
   endfunction

   function automatic logic [31:0] poly(int l);
      return l == 3 ? 32'h04C11DB7 : l == 2 ? 32'h1021 : 32'h07;
   endfunction

   function automatic logic [31:0] init_v(int l);
      return l == 3 ? 32'hFFFFFFFF : l == 2 ? 32'hFFFF : 32'h0;
   endfunction

   function automatic logic [31:0] xor_v(int l);
      return l == 3 ? 32'hFFFFFFFF : 32'h0;
   endfunction

   function automatic logic [31:0] res_v(int l);
      return l == 3 ? 32'h2144DF1C : 32'h0;
   endfunction

   // textbook bitwise CRC over a whole message
   function automatic logic [31:0] model_crc(int l, input byte unsigned m[$]);
      logic [31:0] r, o, mask;
      logic [7:0]  b, br;
      logic        fb;
      int          w = wid(l);
      mask = (w == 32) ? 32'hFFFFFFFF : (32'h1 << w) - 32'h1;
      r = init_v(l);
      foreach (m[j]) begin
         b = m[j];
         br = '0;
         for (int i = 0; i < 8; i++) br[i] = b[7-i];
         if (l == 3) b = br;
         for (int i = 7; i >= 0; i--) begin
            fb = r[w-1] ^ b[i];
            r = (r << 1) & mask;
            if (fb) r = r ^ poly(l);
         end
      end
      if (l == 3) begin
         o = '0;
         for (int i = 0; i < w; i++) o[i] = r[w-1-i];
         r = o;
      end
      return r ^ xor_v(l);
   endfunction

   function automatic logic [31:0] got_crc(int l);
      return l == 0 ? {24'h0, c0} : l == 1 ? {24'h0, c1} : l == 2 ? {16'h0, c2} : c3;
   endfunction

   function automatic logic got_rdy(int l);
      return l == 0 ? r0 : l == 1 ? r1 : l == 2 ? r2 : r3;
   endfunction

   function automatic logic got_cv(int l);
      return l == 0 ? cv0 : l == 1 ? cv1 : l == 2 ? cv2 : cv3;
   endfunction

   function automatic logic got_m(int l);
      return l == 0 ? m0 : l == 1 ? m1 : l == 2 ? m2 : m3;
   endfunction

   task automatic chk(input string nm, input int l, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s lane%0d: got %h expected %h", nm, l, got, exp);
      end
   endtask

   // frame-level model: per lane a byte queue and a pending-result flag
   bit          model_ok = 0;
   bit          hold [4];
   logic [31:0] ecrc [4];
   logic        em [4];
   byte unsigned q [4][$];

   always @(negedge clk) begin
      if (model_ok)
         for (int l = 0; l < 4; l++) begin
            chk("ready", l, {31'h0, got_rdy(l)}, {31'h0, !hold[l] && !rst});
            chk("crc_valid", l, {31'h0, got_cv(l)}, {31'h0, hold[l]});
            if (hold[l]) begin
               chk("crc", l, got_crc(l), ecrc[l]);
               chk("match", l, {31'h0, got_m(l)}, {31'h0, em[l]});
            end
         end
      for (int l = 0; l < 4; l++) begin
         if (rst) begin
            q[l].delete();
            hold[l] = 0;
         end else if (hold[l]) begin
            if (cr) hold[l] = 0;
         end else if (l == 0 ? v1 : valid) begin
            if (l == 0) begin
               if (k1) q[0].push_back(d1);
            end else
               for (int k = 0; k < 4; k++)
                  if (keep[k]) q[l].push_back(data[8*k +: 8]);
            if (l == 0 ? l1 : last) begin
               ecrc[l] = model_crc(l, q[l]);
               em[l]   = ecrc[l] == res_v(l);
               hold[l] = 1;
               q[l].delete();
            end
         end
      end
      if (rst) model_ok = 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input bit rc);
      int n = 0;
      logic acc;
      data = d; keep = k; last = l; valid = 1'b1;
      do begin
         @(negedge clk);
         acc = r1;
         tick();
         if (rc) cr = 1'($urandom_range(0, 1));
         n++;
      end while (acc !== 1'b1 && n < 60);
      if (acc !== 1'b1) chk("bus_accept_timeout", 1, 32'h0, 32'h1);
      valid = 1'b0; last = 1'b0;
   endtask

   task automatic one_beat(input logic [7:0] d, input logic l, input bit rc);
      int n = 0;
      logic acc;
      d1 = d; l1 = l; v1 = 1'b1;
      do begin
         @(negedge clk);
         acc = r0;
         tick();
         if (rc) cr = 1'($urandom_range(0, 1));
         n++;
      end while (acc !== 1'b1 && n < 60);
      if (acc !== 1'b1) chk("lane0_accept_timeout", 0, 32'h0, 32'h1);
      v1 = 1'b0; l1 = 1'b0;
   endtask

   task automatic lane0_frame(input byte unsigned m[$]);
      foreach (m[j]) one_beat(m[j], j == m.size() - 1, 0);
   endtask

   task automatic bus_frame(input byte unsigned m[$], input bit rc);
      logic [31:0] d;
      logic [3:0]  k;
      for (int j = 0; j < m.size(); j += 4) begin
         d = $urandom; k = '0;
         for (int b = 0; b < 4; b++)
            if (j + b < m.size()) begin
               d[8*b +: 8] = m[j+b];
               k[b] = 1'b1;
            end
         bus_beat(d, k, j + 4 >= m.size(), rc);
      end
   endtask

   task automatic wait_cv(input int l);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (got_cv(l) === 1'b1) return;
      end
      chk("result_timeout", l, 32'h0, 32'h1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte unsigned s[$], s2[$], s3[$];
      logic [31:0] saved;
      for (int i = 0; i < 9; i++) s.push_back(8'(8'h31 + i));
      s2 = s; s2.push_back(8'hF4);
      s3 = s; s3.push_back(8'h26); s3.push_back(8'h39); s3.push_back(8'hF4); s3.push_back(8'hCB);
      rst = 1; cr = 1; d1 = 0; k1 = 1; v1 = 0; l1 = 0; data = 0; keep = 0; valid = 0; last = 0;

      chk("model_crc8", 0, model_crc(0, s), 32'hF4);
      chk("model_crc16", 2, model_crc(2, s), 32'h29B1);
      chk("model_crc32", 3, model_crc(3, s), 32'hCBF43926);
      chk("model_crc32_residue", 3, model_crc(3, s3), 32'h2144DF1C);

      repeat (3) tick();
      @(negedge clk);
      chk("ready_in_reset", 1, {31'h0, r1}, 32'h0);
      tick();
      rst = 0;
      @(negedge clk);
      chk("ready_after_reset", 1, {31'h0, r1}, 32'h1);
      chk("crc_reset", 3, c3, 32'h0);
      chk("match_reset", 3, {31'h0, m3}, 32'h0);
      chk("valid_reset", 3, {31'h0, cv3}, 32'h0);
      tick();

      lane0_frame(s);
      wait_cv(0);
      chk("crc8_check", 0, {24'h0, c0}, 32'hF4);
      chk("crc8_nomatch", 0, {31'h0, m0}, 32'h0);
      tick();
      lane0_frame(s2);
      wait_cv(0);
      chk("crc8_residue", 0, {24'h0, c0}, 32'h0);
      chk("crc8_match", 0, {31'h0, m0}, 32'h1);
      tick();

      bus_beat(32'h34333231, 4'hF, 0, 0);
      bus_beat(32'h38373635, 4'hF, 0, 0);
      bus_beat(32'hABCDEF39, 4'b0001, 1, 0);
      wait_cv(2);
      chk("crc16_ccitt", 2, {16'h0, c2}, 32'h29B1);
      tick();

      bus_beat({8'h33, 8'hAA, 8'h32, 8'h31}, 4'b1011, 0, 0);
      bus_beat(32'h37363534, 4'hF, 0, 0);
      bus_beat({16'h5555, 8'h39, 8'h38}, 4'b0011, 1, 0);
      wait_cv(3);
      chk("crc32_gaps", 3, c3, 32'hCBF43926);
      chk("crc16_gaps", 2, {16'h0, c2}, 32'h29B1);
      chk("crc8_gaps", 1, {24'h0, c1}, 32'hF4);
      tick();

      bus_frame(s3, 0);
      wait_cv(3);
      chk("crc32_residue_match", 3, {31'h0, m3}, 32'h1);
      chk("crc32_residue_value", 3, c3, 32'h2144DF1C);
      tick();

      bus_beat(32'hDEADBEEF, 4'h0, 0, 0);
      bus_beat(32'hDEADBEEF, 4'h0, 1, 0);
      wait_cv(2);
      chk("empty_crc16", 2, {16'h0, c2}, 32'hFFFF);
      chk("empty_crc32", 3, c3, 32'h0);
      tick();

      cr = 0;
      bus_frame(s, 0);
      wait_cv(3);
      saved = c3;
      tick();
      for (int i = 0; i < 5; i++) begin
         data = $urandom; keep = 4'hF; valid = 1; last = 1;
         @(negedge clk);
         chk("bp_ready", 3, {31'h0, r3}, 32'h0);
         chk("bp_valid", 3, {31'h0, cv3}, 32'h1);
         chk("bp_crc_stable", 3, c3, saved);
         tick();
      end
      valid = 0; last = 0; cr = 1;
      tick();
      bus_frame(s, 0);
      wait_cv(3);
      chk("after_bp_crc32", 3, c3, 32'hCBF43926);
      tick();

      bus_beat(32'h34333231, 4'hF, 0, 0);
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      chk("midframe_rst_ready", 1, {31'h0, r1}, 32'h1);
      chk("midframe_rst_valid", 3, {31'h0, cv3}, 32'h0);
      tick();
      bus_frame(s, 0);
      wait_cv(3);
      chk("after_midframe_rst", 3, c3, 32'hCBF43926);
      tick();

      cr = 0;
      bus_frame(s, 0);
      wait_cv(3);
      tick();
      rst = 1;
      tick();
      @(negedge clk);
      chk("hold_rst_valid", 3, {31'h0, cv3}, 32'h0);
      tick();
      rst = 0; cr = 1;
      @(negedge clk);
      chk("hold_rst_ready", 1, {31'h0, r1}, 32'h1);
      tick();
      bus_frame(s, 0);
      wait_cv(1);
      chk("after_hold_rst_crc8", 1, {24'h0, c1}, 32'hF4);
      tick();

      for (int f = 0; f < 150; f++) begin
         int nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            bus_beat($urandom, 4'($urandom_range(0, 15)), b == nb - 1, 1);
            repeat ($urandom_range(0, 2)) begin
               tick();
               cr = 1'($urandom_range(0, 1));
            end
         end
      end
      for (int f = 0; f < 40; f++) begin
         int nb = $urandom_range(1, 5);
         for (int b = 0; b < nb; b++) one_beat(8'($urandom_range(0, 255)), b == nb - 1, 1);
      end
      cr = 1;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised streaming CRC engine: the successor to the fixed 8-bit, byte-serial `crc8`. It generalises CRC width, polynomial, init, reflection and output XOR, and accepts up to `DATA_BYTES` bytes per beat with byte-keep. It adds frame delimiting (`last_i`), a valid/ready result handshake with backpressure, and a residue-check flag for frames that carry their own CRC. It sits between packet datapaths and framing/check logic, and is verified alongside a matching `crc_stream_properties` module.

## Interface
- `CRC_WIDTH`, default 8: CRC width in bits, legal range 1..32.
- `POLYNOMIAL`, default `8'h07`: generator polynomial, `CRC_WIDTH` bits, implicit top bit.
- `INIT`, default 0: register value at frame start.
- `XOR_OUT`, default 0: XORed into the final value.
- `REFLECT_IN`, default 0: when 1, each input byte is processed LSB-first.
- `REFLECT_OUT`, default 0: when 1, the final register is bit-reversed before `XOR_OUT`.
- `RESIDUE`, default 0: expected final `crc_o` for a frame that includes its own appended CRC.
- `DATA_BYTES`, default 1: bytes per beat, legal range 1..8.
- `clk_i` in 1: single clock; all logic is rising-edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `data_i` in 8*DATA_BYTES: beat data; byte k is `data_i[8k+7:8k]`, and byte 0 comes first in stream order.
- `keep_i` in DATA_BYTES: bit k set means byte k is processed.
- `valid_i` in 1: beat valid.
- `last_i` in 1: beat is the final beat of the frame.
- `ready_o` out 1: engine accepts a beat.
- `crc_o` out CRC_WIDTH: final CRC of the frame.
- `crc_valid_o` out 1: `crc_o` and `match_o` are valid.
- `crc_ready_i` in 1: consumer accepts the result.
- `match_o` out 1: final `crc_o` equals `RESIDUE`.

## Operation
- Two states, `RUN` and `HOLD`; the state register resets to `RUN`.
- A beat is accepted when `valid_i && ready_o`.
- `ready_o` is 1 in `RUN` and 0 in `HOLD` and while `rst_i` is high. It is driven from the state register only, with no combinational path from `crc_ready_i`.
- In `RUN`, an accepted beat updates the register with every byte whose keep bit is set:
  - bytes are taken in ascending index order;
  - cleared bytes are skipped, and gaps are legal.
- Per byte, with `REFLECT_IN` reversing the byte first: for 8 bits MSB-first, feedback = reg[MSB] ^ bit; shift left; if feedback, XOR `POLYNOMIAL`.
- Accepted beat with `last_i`:
  - bytes are processed as above;
  - the final value is reflect_out(reg) ^ `XOR_OUT` and is registered into `crc_o`;
  - `match_o` is set to (final == `RESIDUE`);
  - the CRC register reloads `INIT`;
  - the state goes to `HOLD`.
- An accepted beat with `keep_i` == 0 and `last_i` == 0 is a no-op. With `keep_i` == 0 and `last_i` == 1, the frame is finalised with no extra bytes, so a zero-length frame yields reflect_out(`INIT`) ^ `XOR_OUT`.
- In `HOLD`:
  - `crc_valid_o` is 1, and `crc_o` and `match_o` are stable;
  - on `crc_ready_i`, the state returns to `RUN`;
  - `crc_o` and `match_o` retain their values after the handshake; they are only meaningful while `crc_valid_o` is 1.
- Inputs other than `crc_ready_i` are ignored in `HOLD`.

## Timing
- Reset values:
  - `crc_valid_o` = 0, `crc_o` = 0, `match_o` = 0;
  - internal register = `INIT`, state `RUN`;
  - `ready_o` = 0 during reset and 1 in the first cycle after `rst_i` is released.
- Reset mid-frame or in `HOLD` discards all progress; a pending result is dropped and no `crc_valid_o` is issued.
- Throughput: one beat per cycle within a frame.
- Result latency: `crc_valid_o` rises in the cycle after the last beat is accepted.
- With `crc_ready_i` held at 1, `HOLD` lasts exactly one cycle. The first beat of the next frame is accepted 2 cycles after the last beat, so there is one bubble per frame.
- All outputs are registered except `ready_o`, which is decoded from the state register.

## Structure
- Package `crc_pkg` holds:
  - functions `reflect8` and `reflect_n`, the latter generic up to 32 bits;
  - localparams `MAX_CRC_WIDTH` = 32 and `MAX_DATA_BYTES` = 8.
- Sub-module `crc_byte_step`: combinational one-byte update (reg, byte, enable → next reg), parametrised like the top. The top instantiates it `DATA_BYTES` times, chained by ascending byte index; a cleared enable passes the register through unchanged.
- Parameter legality is checked at elaboration and stops the build on illegal values.

## Test plan
- CRC-8, default parameters, `DATA_BYTES`=1: "123456789" one byte per beat, `last_i` on '9' → next cycle `crc_valid_o`=1, `crc_o`=0xF4, `match_o`=0.
- Same configuration, "123456789" followed by 0xF4 → `crc_o`=0x00, `match_o`=1.
- CRC-16/CCITT-FALSE (`POLYNOMIAL`=0x1021, `INIT`=0xFFFF), `DATA_BYTES`=4: beats "1234", "5678", "9" with `keep_i`=0001 and `last_i` → `crc_o`=0x29B1.
- CRC-32 (`POLYNOMIAL`=0x04C11DB7, `INIT`=`XOR_OUT`=0xFFFFFFFF, `REFLECT_IN`=`REFLECT_OUT`=1, `RESIDUE`=0x2144DF1C), `DATA_BYTES`=4:
  - "123456789" with keep gaps (e.g. 1011 on a padded beat) → `crc_o`=0xCBF43926;
  - the same data with the CRC appended little-endian → `match_o`=1.
- Backpressure: hold `crc_ready_i`=0 for 5 cycles after the result → `ready_o`=0, while `crc_o` and `crc_valid_o` stay stable and `valid_i` beats are ignored. Then raise `crc_ready_i` → the next frame starts from `INIT` and gives the correct CRC.
- Assert `rst_i` mid-frame and again in `HOLD` → `crc_valid_o` drops to 0 and `ready_o` returns 1 cycle after release. A following "123456789" frame yields the same `crc_o` as from cold reset.
